// File: rtl/core_pkg.sv
// Shared RV32IM core definitions: datapath width, register index width,
// decoded ALU operation codes and the EX-stage control bundle with its
// bubble (all-cleared) value.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Decoded ALU operation codes (5-bit field).
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  // Side-effecting control carried into EX; must be cleared for a bubble.
  typedef struct packed {
    logic rd_we;
    logic mem_re;
    logic mem_we;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: pure combinational load-use comparator.
// Flags when the instruction in ID reads a register that a load currently
// in EX will write. x0 never creates a hazard; a flushed ID never does.
// Ports:
//   ex_valid_i, ex_mem_re_i, ex_rd_addr_i : instruction currently in EX
//   id_valid_i, flush_i                    : ID instruction qualifiers
//   rs1_re_i/rs1_addr_i, rs2_re_i/rs2_addr_i : ID source operands
//   load_use_o                              : hazard present this cycle
module hazard_detect
  import core_pkg::*;
(
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_re_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  id_valid_i,
  input  logic                  flush_i,
  input  logic                  rs1_re_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic                  rs2_re_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = rs1_re_i && (rs1_addr_i == ex_rd_addr_i);
    rs2_hit    = rs2_re_i && (rs2_addr_i == ex_rd_addr_i);
    load_use_o = ex_valid_i && ex_mem_re_i && (ex_rd_addr_i != '0) &&
                 id_valid_i && !flush_i && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID-to-EX pipeline register for the RV32IM core.
// Captures operands and decoded control, inserts a bubble on flush or on a
// load-use hazard, holds on stall, and counts load-use bubbles (saturating).
// Ports:
//   clk, rst_n (async, active-low)
//   stall_i, flush_i            : global pipeline controls
//   id_*                        : decoded ID instruction and its operands
//   ex_*                        : registered EX-stage copies
//   load_use_o                  : combinational hold request to IF/ID
//   bubble_cnt                  : load-use bubbles since reset
module id_ex_stage #(
  parameter int unsigned XLEN     = core_pkg::XLEN,
  parameter int unsigned ALU_OP_W = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            stall_i,
  input  logic                            flush_i,
  input  logic                            id_valid,
  input  logic [XLEN-1:0]                 id_pc,
  input  logic [XLEN-1:0]                 id_imm,
  input  logic                            id_rs1_re,
  input  logic                            id_rs2_re,
  input  logic [core_pkg::REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [core_pkg::REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]                 id_rs1_data,
  input  logic [XLEN-1:0]                 id_rs2_data,
  input  logic [core_pkg::REG_ADDR_W-1:0] id_rd_addr,
  input  logic                            id_rd_we,
  input  logic [ALU_OP_W-1:0]             id_alu_op,
  input  logic                            id_mem_re,
  input  logic                            id_mem_we,
  output logic                            ex_valid,
  output logic [XLEN-1:0]                 ex_pc,
  output logic [XLEN-1:0]                 ex_imm,
  output logic [XLEN-1:0]                 ex_rs1_data,
  output logic [XLEN-1:0]                 ex_rs2_data,
  output logic [core_pkg::REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [core_pkg::REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [core_pkg::REG_ADDR_W-1:0] ex_rd_addr,
  output logic                            ex_rd_we,
  output logic                            ex_mem_re,
  output logic                            ex_mem_we,
  output logic [ALU_OP_W-1:0]             ex_alu_op,
  output logic                            load_use_o,
  output logic [CNT_W-1:0]                bubble_cnt
);

  import core_pkg::*;

  logic                  valid_q,    valid_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [ALU_OP_W-1:0]   alu_op_q,   alu_op_d;
  ex_ctrl_t              ctrl_q,     ctrl_d;
  logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic hazard_bubble;

  hazard_detect u_hazard_detect (
    .ex_valid_i   (valid_q),
    .ex_mem_re_i  (ctrl_q.mem_re),
    .ex_rd_addr_i (rd_addr_q),
    .id_valid_i   (id_valid),
    .flush_i      (flush_i),
    .rs1_re_i     (id_rs1_re),
    .rs1_addr_i   (id_rs1_addr),
    .rs2_re_i     (id_rs2_re),
    .rs2_addr_i   (id_rs2_addr),
    .load_use_o   (load_use)
  );

  always_comb begin
    // Hold by default; covers the stall case.
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    alu_op_d   = alu_op_q;
    ctrl_d     = ctrl_q;
    hazard_bubble = 1'b0;

    if (flush_i || (!stall_i && load_use)) begin
      // Bubble: control cleared, datapath zeroed for deterministic waves.
      valid_d    = 1'b0;
      pc_d       = '0;
      imm_d      = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rd_addr_d  = '0;
      alu_op_d   = '0;
      ctrl_d     = CTRL_BUBBLE;
      // load_use is already masked by flush_i, so only hazards count.
      hazard_bubble = !flush_i;
    end else if (!stall_i) begin
      valid_d       = id_valid;
      pc_d          = id_pc;
      imm_d         = id_imm;
      rs1_data_d    = id_rs1_data;
      rs2_data_d    = id_rs2_data;
      rs1_addr_d    = id_rs1_addr;
      rs2_addr_d    = id_rs2_addr;
      rd_addr_d     = id_rd_addr;
      alu_op_d      = id_alu_op;
      ctrl_d.rd_we  = id_rd_we  && id_valid;
      ctrl_d.mem_re = id_mem_re && id_valid;
      ctrl_d.mem_we = id_mem_we && id_valid;
    end

    bubble_cnt_d = bubble_cnt_q;
    if (hazard_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      alu_op_q     <= '0;
      ctrl_q       <= CTRL_BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
      alu_op_q     <= alu_op_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_imm      = imm_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_rs1_addr = rs1_addr_q;
  assign ex_rs2_addr = rs2_addr_q;
  assign ex_rd_addr  = rd_addr_q;
  assign ex_rd_we    = ctrl_q.rd_we;
  assign ex_mem_re   = ctrl_q.mem_re;
  assign ex_mem_we   = ctrl_q.mem_we;
  assign ex_alu_op   = alu_op_q;
  assign load_use_o  = load_use;
  assign bubble_cnt  = bubble_cnt_q;

endmodule
